// File: rtl/schema_sweep_ctrl.sv
// schema_sweep_ctrl
// Drives a 3-input combinational schema block through all eight input
// vectors in binary order. Each vector is held for SETTLE_CYCLES extra
// cycles, then f is sampled into the observed truth table and compared
// against the host-supplied expected table.
//
// Optional build macro: SCHEMA_SWEEP_EARLY_STOP_EN
//   defined   - the sweep ends at the first mismatching vector
//   undefined - all eight vectors are always swept
//
// state  | meaning
// IDLE   | waiting for start, results held from the previous sweep
// SETTLE | current vector driven, counting down before the sample edge
// DONE   | one-cycle completion pulse, pass flag resolved

module schema_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_bad
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state, state_nxt;
    // vec doubles as the sweep index and the driven {a,b,c} value
    logic [2:0] vec, vec_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] truth_nxt;
    logic [3:0] mismatch_cnt_nxt;
    logic [2:0] first_bad_nxt;
    logic       pass_nxt;
    logic       busy_nxt;
    logic       sample_bad;

    assign a    = vec[2];
    assign b    = vec[1];
    assign c    = vec[0];
    assign done = (state == DONE);

    assign sample_bad = (f != expected[vec]);

    // State and datapath registers; reset aborts any sweep without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= 3'd0;
            cnt          <= 4'd0;
            truth        <= 8'd0;
            mismatch_cnt <= 4'd0;
            first_bad    <= 3'd0;
            pass         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            vec          <= vec_nxt;
            cnt          <= cnt_nxt;
            truth        <= truth_nxt;
            mismatch_cnt <= mismatch_cnt_nxt;
            first_bad    <= first_bad_nxt;
            pass         <= pass_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_nxt        = state;
        vec_nxt          = vec;
        cnt_nxt          = cnt;
        truth_nxt        = truth;
        mismatch_cnt_nxt = mismatch_cnt;
        first_bad_nxt    = first_bad;
        pass_nxt         = pass;
        busy_nxt         = busy;

        case (state)
            IDLE: begin
                if (start) begin
                    vec_nxt          = 3'd0;
                    cnt_nxt          = SETTLE_LD;
                    truth_nxt        = 8'd0;
                    mismatch_cnt_nxt = 4'd0;
                    first_bad_nxt    = 3'd0;
                    pass_nxt         = 1'b0;
                    busy_nxt         = 1'b1;
                    state_nxt        = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    truth_nxt[vec] = f;
                    if (sample_bad) begin
                        mismatch_cnt_nxt = mismatch_cnt + 4'd1;
                        if (mismatch_cnt == 4'd0) begin
                            first_bad_nxt = vec;
                        end
                    end
`ifdef SCHEMA_SWEEP_EARLY_STOP_EN
                    if (sample_bad || (vec == 3'd7)) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt = vec + 3'd1;
                        cnt_nxt = SETTLE_LD;
                    end
`else
                    if (vec == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        vec_nxt = vec + 3'd1;
                        cnt_nxt = SETTLE_LD;
                    end
`endif
                end
            end

            DONE: begin
                busy_nxt  = 1'b0;
                pass_nxt  = (mismatch_cnt == 4'd0);
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
